sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arbiter_if.sv | 25 ++
 rtl/sp_ram_arbiter.sv | 108 ++++++++++
 tb/tb_sp_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_arbiter_if.sv
// Requester-side bundle for sp_ram_arbiter. Signal suffixes (_i/_o) are named
// from the arbiter's point of view, so the requester drives the *_i signals.
interface sp_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    req_i;
    logic                    gnt_o;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM with one-cycle registered read.
// Define SP_RAM_ARB_ROUND_ROBIN_EN for round-robin conflicts; default is fixed priority (port 0).
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    sp_ram_arbiter_if.slave         p0,
    sp_ram_arbiter_if.slave         p1,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_P0   = 2'b01,
        OWN_P1   = 2'b10
    } owner_e;

    owner_e r_owner;
    owner_e w_owner_nxt;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_p0_wins;

`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
    logic r_last_gnt;  // 1 = port 1 was granted most recently

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt0) begin
            r_last_gnt <= 1'b0;
        end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
        end
    end

    assign w_p0_wins = r_last_gnt;
`else
    assign w_p0_wins = 1'b1;
`endif

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else tree can infer a latch.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (p0.req_i && p1.req_i) begin
                w_gnt0 = w_p0_wins;
                w_gnt1 = !w_p0_wins;
            end else begin
                w_gnt0 = p0.req_i;
                w_gnt1 = p1.req_i;
            end
        end
    end

    // Idle cycles leave the port-0 fields on the RAM bus.
    always_comb begin
        ram_addr_o  = p0.addr_i;
        ram_we_o    = p0.we_i;
        ram_be_o    = p0.be_i;
        ram_wdata_o = p0.wdata_i;
        if (w_gnt1) begin
            ram_addr_o  = p1.addr_i;
            ram_we_o    = p1.we_i;
            ram_be_o    = p1.be_i;
            ram_wdata_o = p1.wdata_i;
        end
    end

    assign ram_en_o = w_gnt0 | w_gnt1;

    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_gnt0) begin
            w_owner_nxt = OWN_P0;
        end else if (w_gnt1) begin
            w_owner_nxt = OWN_P1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Gating with rst drops a response still owed when reset lands mid-access.
    assign p0.gnt_o    = w_gnt0;
    assign p1.gnt_o    = w_gnt1;
    assign p0.rvalid_o = !rst && (r_owner == OWN_P0);
    assign p1.rvalid_o = !rst && (r_owner == OWN_P1);
    assign p0.rdata_o  = ram_rdata_i;
    assign p1.rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model (shadow memory + arbitration rule).
module tb_sp_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .p0          (p0_if),
        .p1          (p1_if),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < BW; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Single-port RAM with one-cycle registered read, word-addressed by addr[11:2].
    logic [DW-1:0] ram_mem [0:1023];
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) ram_mem[ram_addr_o[11:2]] <= merge(ram_mem[ram_addr_o[11:2]], ram_wdata_o, ram_be_o);
            else          ram_rdata_i <= ram_mem[ram_addr_o[11:2]];
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:1023];
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
    logic          m_last;
`endif
    logic          exp_rv0, exp_rv1, exp_isrd;
    logic [DW-1:0] exp_rd;

    // Values sampled during the latest step.
    logic          s_g0, s_g1, s_en, s_rv0, s_rv1;
    logic [DW-1:0] s_rd0, s_rd1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic acc_t idle();
        return '0;
    endfunction

    function automatic acc_t rd(input logic [AW-1:0] a);
        acc_t r = '0;
        r.req = 1'b1; r.addr = a; r.be = '1;
        return r;
    endfunction

    function automatic acc_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        acc_t r;
        r.req = 1'b1; r.we = 1'b1; r.addr = a; r.be = be; r.wdata = d;
        return r;
    endfunction

    task automatic commit(input acc_t x);
        if (x.we) begin
            ref_mem[x.addr[11:2]] = merge(ref_mem[x.addr[11:2]], x.wdata, x.be);
            exp_isrd = 1'b0;
        end else begin
            exp_rd   = ref_mem[x.addr[11:2]];
            exp_isrd = 1'b1;
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input logic rst_v, input acc_t a, input acc_t b);
        logic eg0, eg1;
        rst           = rst_v;
        p0_if.req_i   = a.req;  p0_if.we_i = a.we;  p0_if.addr_i = a.addr;
        p0_if.be_i    = a.be;   p0_if.wdata_i = a.wdata;
        p1_if.req_i   = b.req;  p1_if.we_i = b.we;  p1_if.addr_i = b.addr;
        p1_if.be_i    = b.be;   p1_if.wdata_i = b.wdata;
        @(negedge clk);

        if (rst_v) begin
            eg0 = 1'b0; eg1 = 1'b0;
        end else if (a.req && b.req) begin
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
            eg0 = m_last;
`else
            eg0 = 1'b1;
`endif
            eg1 = !eg0;
        end else begin
            eg0 = a.req; eg1 = b.req;
        end

        s_g0 = p0_if.gnt_o;    s_g1 = p1_if.gnt_o;   s_en = ram_en_o;
        s_rv0 = p0_if.rvalid_o; s_rv1 = p1_if.rvalid_o;
        s_rd0 = p0_if.rdata_o;  s_rd1 = p1_if.rdata_o;

        chk("gnt0",   s_g0, eg0);
        chk("gnt1",   s_g1, eg1);
        chk("ram_en", s_en, eg0 | eg1);
        if (!rst_v) begin
            chk("ram_addr",  ram_addr_o,          eg1 ? b.addr : a.addr);
            chk("ram_we_be", {ram_we_o, ram_be_o}, eg1 ? {b.we, b.be} : {a.we, a.be});
            chk("ram_wdata", ram_wdata_o,         eg1 ? b.wdata : a.wdata);
        end
        chk("rvalid0", s_rv0, rst_v ? 1'b0 : exp_rv0);
        chk("rvalid1", s_rv1, rst_v ? 1'b0 : exp_rv1);
        if (!rst_v && exp_isrd && exp_rv0) chk("rdata0", s_rd0, exp_rd);
        if (!rst_v && exp_isrd && exp_rv1) chk("rdata1", s_rd1, exp_rd);

        if (rst_v) begin
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
            m_last = 1'b1;
`endif
            exp_rv0 = 1'b0; exp_rv1 = 1'b0;
        end else begin
            exp_rv0 = eg0; exp_rv1 = eg1;
            if (eg0) commit(a);
            if (eg1) commit(b);
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
            if (eg0) m_last = 1'b0;
            if (eg1) m_last = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        acc_t ra, rb;
        logic eg;
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_isrd = 1'b0; exp_rd = '0;
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
        m_last = 1'b1;
`endif

        // Reset with both ports requesting: everything must stay quiet.
        step(1'b1, rd(12'h010), rd(12'h020));
        step(1'b1, idle(), idle());
        chk("rst_quiet", {s_g0, s_g1, s_en, s_rv0, s_rv1}, '0);

        // Idle after reset, then a lone p1 request.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, idle(), idle());
            chk("idle_quiet", {s_en, s_rv0, s_rv1}, '0);
        end
        step(1'b0, idle(), rd(12'h010));
        chk("first_p1_gnt", s_g1, 1'b1);

        // p0 write then p1 read of the same word.
        step(1'b0, wr(12'h010, 32'hDEADBEEF, 4'hF), idle());
        step(1'b0, idle(), rd(12'h010));
        step(1'b0, idle(), idle());
        chk("wr_rd_rvalid1", s_rv1, 1'b1);
        chk("wr_rd_rdata1",  s_rd1, 32'hDEADBEEF);

        // Partial-byte write over an existing word.
        step(1'b0, wr(12'h020, 32'hAABBCCDD, 4'hF), idle());
        step(1'b0, wr(12'h020, 32'h11223344, 4'h3), idle());
        step(1'b0, rd(12'h020), idle());
        step(1'b0, idle(), idle());
        chk("be_rvalid0", s_rv0, 1'b1);
        chk("be_rdata0",  s_rd0, 32'hAABB3344);

        // Sustained conflict straight after reset.
        step(1'b1, idle(), idle());
        for (int i = 0; i < 4; i++) begin
            step(1'b0, rd(12'h010), rd(12'h020));
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
            eg = (i % 2 == 0);
`else
            eg = 1'b1;
`endif
            chk("conflict_g0", s_g0, eg);
            chk("conflict_g1", s_g1, !eg);
        end
        step(1'b0, idle(), idle());

        // Back-to-back alternating ports, no bubbles.
        step(1'b0, wr(12'h030, 32'hCAFEF00D, 4'hF), idle());
        step(1'b0, idle(), rd(12'h030));
        step(1'b0, rd(12'h010), idle());
        step(1'b0, idle(), wr(12'h034, 32'h01234567, 4'hC));
        step(1'b0, rd(12'h034), idle());
        step(1'b0, idle(), idle());

        // Reset one cycle after a p1 read grant drops the response.
        step(1'b0, idle(), rd(12'h030));
        step(1'b1, idle(), idle());
        chk("rst_drop_rv1", s_rv1, 1'b0);
        step(1'b1, idle(), idle());
        step(1'b0, idle(), idle());
        chk("post_rst_rv1", s_rv1, 1'b0);
        step(1'b0, idle(), idle());
        chk("post_rst_rv1b", s_rv1, 1'b0);

        // Random traffic, including occasional reset and changing requests.
        for (int n = 0; n < 400; n++) begin
            ra.req = 1'($urandom_range(0, 1)); ra.we = 1'($urandom_range(0, 1));
            ra.addr = AW'($urandom_range(0, 63)); ra.be = BW'($urandom); ra.wdata = $urandom;
            rb.req = 1'($urandom_range(0, 1)); rb.we = 1'($urandom_range(0, 1));
            rb.addr = AW'($urandom_range(0, 63)); rb.be = BW'($urandom); rb.wdata = $urandom;
            step($urandom_range(0, 39) == 0, ra, rb);
        end
        step(1'b0, idle(), idle());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
